// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one main-memory port between the I-cache miss path and
// the D-cache miss/writeback path.
//   clk, rst            : clock, synchronous active-high reset
//   ic_req_* / ic_wr_data: I-cache one-word request, held until ic_req_ready
//   ic_req_data/ready/err: registered response (ready is a 1-cycle pulse)
//   dc_req_* / dc_lock   : D-cache request; dc_lock keeps ownership after DONE
//   dc_req_data/ready/err: registered response to the D-cache
//   mem_req_*            : registered memory request, held while valid
//   mem_req_data/ready   : memory completion and read data
// Round-robin between caches; a TIMEOUT > 0 bounds each memory access and
// completes it with an error pulse.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ic_req_addr,
    input  logic              ic_req_valid,
    input  logic              ic_req_wr,
    input  logic [DATA_W-1:0] ic_wr_data,
    output logic [DATA_W-1:0] ic_req_data,
    output logic              ic_req_ready,
    output logic              ic_req_err,
    input  logic [ADDR_W-1:0] dc_req_addr,
    input  logic              dc_req_valid,
    input  logic              dc_req_wr,
    input  logic [DATA_W-1:0] dc_wr_data,
    input  logic              dc_lock,
    output logic [DATA_W-1:0] dc_req_data,
    output logic              dc_req_ready,
    output logic              dc_req_err,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic              mem_req_valid,
    output logic              mem_req_wr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_req_data,
    input  logic              mem_req_ready
);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W:0] TO_LIM = (CNT_W + 1)'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, DONE} state_t;

    state_t            state_q, state_d;
    logic              last_is_d_q, last_is_d_d;   // owner of the most recent grant
    logic              dlock_q, dlock_d;           // D-cache holds exclusive ownership
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] maddr_q, maddr_d;
    logic              mvalid_q, mvalid_d;
    logic              mwr_q, mwr_d;
    logic [DATA_W-1:0] mwdata_q, mwdata_d;
    logic [DATA_W-1:0] icdata_q, icdata_d, dcdata_q, dcdata_d;
    logic              icrdy_q, icrdy_d, icerr_q, icerr_d;
    logic              dcrdy_q, dcrdy_d, dcerr_q, dcerr_d;
    logic              grant_i, grant_d, timed_out, finish;

    // Access expires on the cycle the count would reach TIMEOUT; a real
    // completion in that same cycle takes priority over the error.
    assign timed_out = (TIMEOUT > 0) && (({1'b0, cnt_q} + 1'b1) == TO_LIM);
    assign finish    = mem_req_ready || timed_out;

    always_comb begin
        state_d     = state_q;
        last_is_d_d = last_is_d_q;
        dlock_d     = dlock_q;
        cnt_d       = cnt_q;
        maddr_d     = maddr_q;
        mvalid_d    = mvalid_q;
        mwr_d       = mwr_q;
        mwdata_d    = mwdata_q;
        icdata_d    = icdata_q;
        dcdata_d    = dcdata_q;
        icrdy_d     = 1'b0;
        icerr_d     = 1'b0;
        dcrdy_d     = 1'b0;
        dcerr_d     = 1'b0;
        grant_i     = 1'b0;
        grant_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (dlock_q) begin
                    // Locked: the I-cache waits even if the D-cache is idle.
                    grant_d = dc_req_valid;
                end else if (ic_req_valid && dc_req_valid) begin
                    grant_d = ~last_is_d_q;
                    grant_i = last_is_d_q;
                end else begin
                    grant_d = dc_req_valid;
                    grant_i = ic_req_valid;
                end
                if (grant_d) begin
                    maddr_d     = dc_req_addr;
                    mwr_d       = dc_req_wr;
                    mwdata_d    = dc_wr_data;
                    mvalid_d    = 1'b1;
                    last_is_d_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = GRANT_D;
                end else if (grant_i) begin
                    maddr_d     = ic_req_addr;
                    mwr_d       = ic_req_wr;
                    mwdata_d    = ic_wr_data;
                    mvalid_d    = 1'b1;
                    last_is_d_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = GRANT_I;
                end
            end
            GRANT_I, GRANT_D: begin
                if (finish) begin
                    mvalid_d = 1'b0;
                    state_d  = DONE;
                    if (state_q == GRANT_I) begin
                        icrdy_d = 1'b1;
                        icerr_d = ~mem_req_ready;
                        if (mem_req_ready && !mwr_q) icdata_d = mem_req_data;
                    end else begin
                        dcrdy_d = 1'b1;
                        dcerr_d = ~mem_req_ready;
                        if (mem_req_ready && !mwr_q) dcdata_d = mem_req_data;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                // Lock is sampled while the D-cache still holds its request.
                dlock_d = last_is_d_q ? dc_lock : 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            last_is_d_q <= 1'b0;
            dlock_q     <= 1'b0;
            cnt_q       <= '0;
            maddr_q     <= '0;
            mvalid_q    <= 1'b0;
            mwr_q       <= 1'b0;
            mwdata_q    <= '0;
            icdata_q    <= '0;
            dcdata_q    <= '0;
            icrdy_q     <= 1'b0;
            icerr_q     <= 1'b0;
            dcrdy_q     <= 1'b0;
            dcerr_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_is_d_q <= last_is_d_d;
            dlock_q     <= dlock_d;
            cnt_q       <= cnt_d;
            maddr_q     <= maddr_d;
            mvalid_q    <= mvalid_d;
            mwr_q       <= mwr_d;
            mwdata_q    <= mwdata_d;
            icdata_q    <= icdata_d;
            dcdata_q    <= dcdata_d;
            icrdy_q     <= icrdy_d;
            icerr_q     <= icerr_d;
            dcrdy_q     <= dcrdy_d;
            dcerr_q     <= dcerr_d;
        end
    end

    assign ic_req_data   = icdata_q;
    assign ic_req_ready  = icrdy_q;
    assign ic_req_err    = icerr_q;
    assign dc_req_data   = dcdata_q;
    assign dc_req_ready  = dcrdy_q;
    assign dc_req_err    = dcerr_q;
    assign mem_req_addr  = maddr_q;
    assign mem_req_valid = mvalid_q;
    assign mem_req_wr    = mwr_q;
    assign mem_wr_data   = mwdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-order reference model.
module tb_mem_arbiter;
    localparam int AW = 32, DW = 32, TO = 4;

    logic clk = 1'b0, rst;
    logic [AW-1:0] ic_req_addr, dc_req_addr, mem_req_addr;
    logic ic_req_valid, ic_req_wr, dc_req_valid, dc_req_wr, dc_lock;
    logic [DW-1:0] ic_wr_data, dc_wr_data, ic_req_data, dc_req_data;
    logic ic_req_ready, ic_req_err, dc_req_ready, dc_req_err;
    logic mem_req_valid, mem_req_wr, mem_req_ready;
    logic [DW-1:0] mem_wr_data, mem_req_data;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .ic_req_addr(ic_req_addr), .ic_req_valid(ic_req_valid), .ic_req_wr(ic_req_wr),
        .ic_wr_data(ic_wr_data), .ic_req_data(ic_req_data), .ic_req_ready(ic_req_ready),
        .ic_req_err(ic_req_err),
        .dc_req_addr(dc_req_addr), .dc_req_valid(dc_req_valid), .dc_req_wr(dc_req_wr),
        .dc_wr_data(dc_wr_data), .dc_lock(dc_lock), .dc_req_data(dc_req_data),
        .dc_req_ready(dc_req_ready), .dc_req_err(dc_req_err),
        .mem_req_addr(mem_req_addr), .mem_req_valid(mem_req_valid), .mem_req_wr(mem_req_wr),
        .mem_wr_data(mem_wr_data), .mem_req_data(mem_req_data), .mem_req_ready(mem_req_ready)
    );

    typedef struct { logic [AW-1:0] addr; logic wr; logic [DW-1:0] wdata; logic lock; } req_t;
    typedef struct { logic [DW-1:0] data; logic err; int cyc; } rsp_t;
    typedef struct { logic [AW-1:0] addr; logic wr; logic [DW-1:0] wdata; } mtx_t;

    int errors = 0, checks = 0, cyc = 0;
    req_t iq[$], dq[$], expq[$];
    rsp_t ic_rsp[$], dc_rsp[$];
    mtx_t mlog[$];
    logic [DW-1:0] exp_ic[$], exp_dc[$];
    logic [DW-1:0] exp_ic_data, exp_dc_data;
    logic [DW-1:0] mem_arr [logic [AW-1:0]];
    logic [DW-1:0] ref_mem [logic [AW-1:0]];

    always @(posedge clk) cyc++;

    function automatic logic [DW-1:0] init_word(logic [AW-1:0] a);
        return (a * 32'h9E3779B9) ^ 32'h5A5A0000;
    endfunction

    // ---------------- memory responder ----------------
    int mem_lat = 1;       // ready in the mem_lat-th valid cycle; 0 = never
    bit mem_always = 0, mem_force_rdy = 0, rand_lat = 0;
    int vcnt = 0;
    always @(negedge clk) begin
        logic rdy;
        if (rst || !mem_req_valid) vcnt = 0; else vcnt++;
        if (rand_lat && vcnt == 1) mem_lat = $urandom_range(1, TO);
        rdy = mem_always || mem_force_rdy || (mem_req_valid && mem_lat != 0 && vcnt == mem_lat);
        mem_req_ready = rdy;
        if (mem_req_valid)
            mem_req_data = mem_arr.exists(mem_req_addr) ? mem_arr[mem_req_addr] : init_word(mem_req_addr);
        else
            mem_req_data = $urandom;
        if (rdy && mem_req_valid && mem_req_wr && !rst) mem_arr[mem_req_addr] = mem_wr_data;
    end

    // ---------------- protocol monitor / logs ----------------
    int viol_both = 0, viol_long = 0, viol_unstable = 0;
    logic pic = 0, pdc = 0, pv = 0, pwr = 0;
    logic [AW-1:0] paddr = '0;
    logic [DW-1:0] pwd = '0;
    always @(negedge clk) begin
        if (ic_req_ready && dc_req_ready) viol_both++;
        if ((ic_req_ready && pic) || (dc_req_ready && pdc)) viol_long++;
        if (mem_req_valid && pv && (mem_req_addr !== paddr || mem_req_wr !== pwr || mem_wr_data !== pwd))
            viol_unstable++;
        if (mem_req_valid && !pv) mlog.push_back('{mem_req_addr, mem_req_wr, mem_wr_data});
        if (ic_req_ready) ic_rsp.push_back('{ic_req_data, ic_req_err, cyc});
        if (dc_req_ready) dc_rsp.push_back('{dc_req_data, dc_req_err, cyc});
        pic = ic_req_ready; pdc = dc_req_ready; pv = mem_req_valid;
        paddr = mem_req_addr; pwr = mem_req_wr; pwd = mem_wr_data;
    end

    // ---------------- reference model ----------------
    // Grant order from the arbitration rules, assuming both caches present
    // their queued requests back to back and the arbiter starts from reset.
    function automatic void predict();
        int i = 0, d = 0;
        bit last_d = 0, lk = 0, pick_d;
        req_t r;
        logic [DW-1:0] rd;
        expq.delete(); exp_ic.delete(); exp_dc.delete(); ref_mem.delete();
        while (i < iq.size() || d < dq.size()) begin
            if (lk) pick_d = 1;
            else if (i < iq.size() && d < dq.size()) pick_d = !last_d;
            else pick_d = (d < dq.size());
            if (pick_d && d >= dq.size()) break;
            if (pick_d) begin r = dq[d]; d++; end
            else begin r = iq[i]; i++; end
            if (r.wr) ref_mem[r.addr] = r.wdata;
            else begin
                rd = ref_mem.exists(r.addr) ? ref_mem[r.addr] : init_word(r.addr);
                if (pick_d) exp_dc_data = rd; else exp_ic_data = rd;
            end
            if (pick_d) exp_dc.push_back(exp_dc_data); else exp_ic.push_back(exp_ic_data);
            last_d = pick_d;
            lk = pick_d ? r.lock : 1'b0;
            expq.push_back(r);
        end
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        rst = 1; ic_req_valid = 0; dc_req_valid = 0; dc_lock = 0;
        mem_always = 0; mem_force_rdy = 0; rand_lat = 0; mem_lat = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        mem_arr.delete();
        exp_ic_data = '0; exp_dc_data = '0;
    endtask

    task automatic drive_ic(output bit hung);
        hung = 0;
        foreach (iq[k]) begin
            int n = 0;
            ic_req_addr = iq[k].addr; ic_req_wr = iq[k].wr; ic_wr_data = iq[k].wdata; ic_req_valid = 1;
            do begin @(negedge clk); n++; end while (!ic_req_ready && n < 200);
            if (!ic_req_ready) hung = 1;
            @(posedge clk); #1;
        end
        ic_req_valid = 0;
    endtask

    task automatic drive_dc(output bit hung);
        hung = 0;
        foreach (dq[k]) begin
            int n = 0;
            dc_req_addr = dq[k].addr; dc_req_wr = dq[k].wr; dc_wr_data = dq[k].wdata;
            dc_lock = dq[k].lock; dc_req_valid = 1;
            do begin @(negedge clk); n++; end while (!dc_req_ready && n < 200);
            if (!dc_req_ready) hung = 1;
            @(posedge clk); #1;
        end
        dc_req_valid = 0; dc_lock = 0;
    endtask

    task automatic run_traffic(output bit hung);
        bit h1, h2;
        predict();
        @(posedge clk); #1;
        ic_rsp.delete(); dc_rsp.delete(); mlog.delete();
        viol_both = 0; viol_long = 0; viol_unstable = 0;
        fork
            drive_ic(h1);
            drive_dc(h2);
        join
        repeat (3) @(posedge clk);
        #1 hung = h1 | h2;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [133:0] v;
        do_reset();
        @(negedge clk);
        v = {ic_req_data, ic_req_ready, ic_req_err, dc_req_data, dc_req_ready, dc_req_err,
             mem_req_addr, mem_req_valid, mem_req_wr, mem_wr_data};
        checks++;
        if (v !== '0) begin errors++; $display("FAIL reset_outputs: got %h want 0", v); end
        @(posedge clk); #1;
    endtask

    task automatic test_single_read();
        int t0, n = 0;
        do_reset();
        mem_arr[32'h40] = 32'hDEADBEEF; mem_lat = 4;
        ic_req_addr = 32'h40; ic_req_wr = 0; ic_wr_data = $urandom; ic_req_valid = 1;
        @(negedge clk); t0 = cyc;
        @(negedge clk);
        checks++;
        if ({mem_req_valid, mem_req_addr, mem_req_wr} !== {1'b1, 32'h40, 1'b0}) begin
            errors++; $display("FAIL single_mem_req: got v=%b a=%h w=%b want v=1 a=40 w=0",
                               mem_req_valid, mem_req_addr, mem_req_wr);
        end
        while (!ic_req_ready && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (cyc - t0 !== 5) begin errors++; $display("FAIL single_latency: got %0d want 5", cyc - t0); end
        checks++;
        if ({ic_req_data, ic_req_err} !== {32'hDEADBEEF, 1'b0}) begin
            errors++; $display("FAIL single_data: got %h err=%b want deadbeef err=0", ic_req_data, ic_req_err);
        end
        @(posedge clk); #1 ic_req_valid = 0;
        @(negedge clk);
        checks++;
        if (ic_req_ready !== 1'b0) begin errors++; $display("FAIL single_pulse: ready %b want 0", ic_req_ready); end
        exp_ic_data = 32'hDEADBEEF;
        @(posedge clk); #1;
    endtask

    task automatic test_timeout();
        int t0, n = 0, vc = 0;
        logic [AW-1:0] b;
        mem_lat = 0;
        ic_req_addr = 32'h80; ic_req_wr = 0; ic_req_valid = 1;
        @(negedge clk); t0 = cyc;
        do begin @(negedge clk); n++; if (mem_req_valid) vc++; end while (!ic_req_ready && n < 20);
        checks++;
        if (vc !== TO) begin errors++; $display("FAIL timeout_valid_cycles: got %0d want %0d", vc, TO); end
        checks++;
        if ({ic_req_ready, ic_req_err, ic_req_data} !== {2'b11, exp_ic_data} || cyc - t0 !== TO + 1) begin
            errors++; $display("FAIL timeout_err: got rdy=%b err=%b d=%h t=%0d want 1 1 %h t=%0d",
                               ic_req_ready, ic_req_err, ic_req_data, cyc - t0, exp_ic_data, TO + 1);
        end
        @(posedge clk); #1 ic_req_valid = 0;
        @(negedge clk);
        checks++;
        if ({ic_req_ready, ic_req_err, mem_req_valid} !== 3'b000) begin
            errors++; $display("FAIL timeout_pulse: got %b want 000", {ic_req_ready, ic_req_err, mem_req_valid});
        end
        @(posedge clk); #1;
        mem_lat = 2; b = ($urandom & 32'h0FFC) | 32'h1000; n = 0;
        ic_req_addr = b; ic_req_valid = 1;
        @(negedge clk); t0 = cyc;
        do begin @(negedge clk); n++; end while (!ic_req_ready && n < 20);
        checks++;
        if ({ic_req_data, ic_req_err} !== {init_word(b), 1'b0} || cyc - t0 !== 3) begin
            errors++; $display("FAIL after_timeout: got d=%h err=%b t=%0d want %h 0 t=3",
                               ic_req_data, ic_req_err, cyc - t0, init_word(b));
        end
        @(posedge clk); #1 ic_req_valid = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_round_robin();
        bit hung;
        do_reset(); mem_lat = 1;
        iq.delete(); dq.delete();
        for (int k = 0; k < 2; k++) begin
            iq.push_back('{32'h1000 + 4 * k, 1'b0, 32'h0, 1'b0});
            dq.push_back('{32'h2000 + 4 * k, 1'b0, 32'h0, 1'b0});
        end
        run_traffic(hung);
        checks++;
        if (hung || mlog.size() != 4 || ic_rsp.size() != 2 || dc_rsp.size() != 2) begin
            errors++; $display("FAIL rr_counts: got hung=%b m=%0d i=%0d d=%0d want 0 4 2 2",
                               hung, mlog.size(), ic_rsp.size(), dc_rsp.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (mlog[k].addr !== expq[k].addr) begin
                    errors++; $display("FAIL rr_order[%0d]: got %h want %h", k, mlog[k].addr, expq[k].addr);
                end
            end
            checks++;
            if (!(dc_rsp[0].cyc < ic_rsp[0].cyc && ic_rsp[0].cyc < dc_rsp[1].cyc && dc_rsp[1].cyc < ic_rsp[1].cyc)) begin
                errors++; $display("FAIL rr_pulses: got d%0d i%0d d%0d i%0d want dc,ic,dc,ic",
                                   dc_rsp[0].cyc, ic_rsp[0].cyc, dc_rsp[1].cyc, ic_rsp[1].cyc);
            end
            checks++;
            if (ic_rsp[1].data !== exp_ic[1] || dc_rsp[1].data !== exp_dc[1]) begin
                errors++; $display("FAIL rr_data: got %h %h want %h %h",
                                   ic_rsp[1].data, dc_rsp[1].data, exp_ic[1], exp_dc[1]);
            end
        end
    endtask

    task automatic test_lock();
        bit hung;
        do_reset(); mem_lat = $urandom_range(1, 3);
        iq.delete(); dq.delete();
        iq.push_back('{32'h104, 1'b0, 32'h0, 1'b0});
        for (int k = 0; k < 4; k++) dq.push_back('{32'h100 + 4 * k, 1'b1, 32'h12345678, k < 3});
        run_traffic(hung);
        checks++;
        if (hung || mlog.size() != 5 || ic_rsp.size() != 1 || dc_rsp.size() != 4) begin
            errors++; $display("FAIL lock_counts: got hung=%b m=%0d i=%0d d=%0d want 0 5 1 4",
                               hung, mlog.size(), ic_rsp.size(), dc_rsp.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (mlog[k].addr !== expq[k].addr || mlog[k].wr !== expq[k].wr) begin
                    errors++; $display("FAIL lock_order[%0d]: got %h/%b want %h/%b",
                                       k, mlog[k].addr, mlog[k].wr, expq[k].addr, expq[k].wr);
                end
            end
            checks++;
            if (ic_rsp[0].cyc <= dc_rsp[3].cyc || ic_rsp[0].data !== 32'h12345678) begin
                errors++; $display("FAIL lock_ic: got t=%0d d=%h want t>%0d d=12345678",
                                   ic_rsp[0].cyc, ic_rsp[0].data, dc_rsp[3].cyc);
            end
            checks++;
            if (dc_rsp[3].data !== 32'h0) begin
                errors++; $display("FAIL lock_wr_data: got %h want 0", dc_rsp[3].data);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit hung;
        do_reset(); mem_lat = 0;
        dc_req_addr = 32'h500; dc_req_wr = 0; dc_req_valid = 1;
        @(negedge clk); @(negedge clk);
        checks++;
        if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre: valid %b want 1", mem_req_valid); end
        @(posedge clk); #1 rst = 1; dc_req_valid = 0;
        @(posedge clk); #1 rst = 0; mem_force_rdy = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if ({mem_req_valid, dc_req_ready, ic_req_ready} !== 3'b000) begin
                errors++; $display("FAIL rstmid_quiet[%0d]: got %b want 000", k,
                                   {mem_req_valid, dc_req_ready, ic_req_ready});
            end
        end
        @(posedge clk); #1 mem_force_rdy = 0; mem_lat = 1;
        mem_arr.delete(); exp_ic_data = '0; exp_dc_data = '0;
        iq.delete(); dq.delete();
        iq.push_back('{32'h600, 1'b0, 32'h0, 1'b0});
        dq.push_back('{32'h700, 1'b0, 32'h0, 1'b0});
        run_traffic(hung);
        checks++;
        if (hung || mlog.size() != 2 || mlog[0].addr !== 32'h700 || dc_rsp.size() != 1 || ic_rsp.size() != 1) begin
            errors++; $display("FAIL rstmid_first_d: got hung=%b m=%0d a0=%h want D first at 700",
                               hung, mlog.size(), (mlog.size() > 0) ? mlog[0].addr : 32'hX);
        end
    endtask

    task automatic test_always_ready();
        bit hung;
        int allc[$];
        do_reset(); mem_always = 1;
        iq.delete(); dq.delete();
        for (int k = 0; k < 3; k++) begin
            iq.push_back('{32'h800 + 4 * $urandom_range(0, 3), 1'($urandom), $urandom, 1'b0});
            dq.push_back('{32'h800 + 4 * $urandom_range(0, 3), 1'($urandom), $urandom, 1'b0});
        end
        run_traffic(hung);
        mem_always = 0;
        checks++;
        if (hung || mlog.size() != 6 || ic_rsp.size() != 3 || dc_rsp.size() != 3) begin
            errors++; $display("FAIL ar_counts: got hung=%b m=%0d i=%0d d=%0d want 0 6 3 3",
                               hung, mlog.size(), ic_rsp.size(), dc_rsp.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (mlog[k].addr !== expq[k].addr || mlog[k].wr !== expq[k].wr ||
                    (expq[k].wr && mlog[k].wdata !== expq[k].wdata)) begin
                    errors++; $display("FAIL ar_order[%0d]: got %h/%b/%h want %h/%b/%h", k, mlog[k].addr,
                                       mlog[k].wr, mlog[k].wdata, expq[k].addr, expq[k].wr, expq[k].wdata);
                end
            end
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (ic_rsp[k].data !== exp_ic[k] || dc_rsp[k].data !== exp_dc[k]) begin
                    errors++; $display("FAIL ar_data[%0d]: got %h %h want %h %h", k,
                                       ic_rsp[k].data, dc_rsp[k].data, exp_ic[k], exp_dc[k]);
                end
                allc.push_back(ic_rsp[k].cyc); allc.push_back(dc_rsp[k].cyc);
            end
            allc.sort();
            for (int k = 1; k < 6; k++) begin
                checks++;
                if (allc[k] - allc[k-1] !== 3) begin
                    errors++; $display("FAIL ar_spacing[%0d]: got %0d want 3", k, allc[k] - allc[k-1]);
                end
            end
        end
        checks++;
        if (viol_both + viol_long + viol_unstable !== 0) begin
            errors++; $display("FAIL ar_protocol: both=%0d long=%0d unstable=%0d want 0",
                               viol_both, viol_long, viol_unstable);
        end
    endtask

    task automatic test_random();
        bit hung;
        do_reset(); rand_lat = 1;
        iq.delete(); dq.delete();
        for (int k = 0; k < 6; k++)
            iq.push_back('{32'h300 + 4 * $urandom_range(0, 7), 1'($urandom), $urandom, 1'b0});
        for (int k = 0; k < 8; k++)
            dq.push_back('{32'h300 + 4 * $urandom_range(0, 7), 1'($urandom), $urandom, (k < 7) ? 1'($urandom) : 1'b0});
        run_traffic(hung);
        rand_lat = 0;
        checks++;
        if (hung || mlog.size() != 14 || ic_rsp.size() != 6 || dc_rsp.size() != 8) begin
            errors++; $display("FAIL rnd_counts: got hung=%b m=%0d i=%0d d=%0d want 0 14 6 8",
                               hung, mlog.size(), ic_rsp.size(), dc_rsp.size());
        end else begin
            for (int k = 0; k < 14; k++) begin
                checks++;
                if (mlog[k].addr !== expq[k].addr || mlog[k].wr !== expq[k].wr ||
                    (expq[k].wr && mlog[k].wdata !== expq[k].wdata)) begin
                    errors++; $display("FAIL rnd_order[%0d]: got %h/%b want %h/%b", k,
                                       mlog[k].addr, mlog[k].wr, expq[k].addr, expq[k].wr);
                end
            end
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (ic_rsp[k].data !== exp_ic[k] || ic_rsp[k].err !== 1'b0) begin
                    errors++; $display("FAIL rnd_ic[%0d]: got %h/%b want %h/0", k, ic_rsp[k].data, ic_rsp[k].err, exp_ic[k]);
                end
            end
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (dc_rsp[k].data !== exp_dc[k] || dc_rsp[k].err !== 1'b0) begin
                    errors++; $display("FAIL rnd_dc[%0d]: got %h/%b want %h/0", k, dc_rsp[k].data, dc_rsp[k].err, exp_dc[k]);
                end
            end
        end
        checks++;
        if (viol_both + viol_long + viol_unstable !== 0) begin
            errors++; $display("FAIL rnd_protocol: both=%0d long=%0d unstable=%0d want 0",
                               viol_both, viol_long, viol_unstable);
        end
    endtask

    initial begin
        rst = 1; ic_req_addr = '0; ic_req_valid = 0; ic_req_wr = 0; ic_wr_data = '0;
        dc_req_addr = '0; dc_req_valid = 0; dc_req_wr = 0; dc_wr_data = '0; dc_lock = 0;
        mem_req_ready = 0; mem_req_data = '0;
        test_reset();
        test_single_read();
        test_timeout();
        test_round_robin();
        test_lock();
        test_reset_mid();
        test_always_ready();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end
endmodule
